feed_a: RTL and testbench

- Upstream feeder for the systolic array whose C results are collected by gather_c.
- Reads matrix A tiles from BRAM A, one N-element row segment per cycle.
- Skews the segment diagonally: lane i is delayed i cycles.
- Drives the array's a_ins. Block-by-block progress is paced by an acknowledge from the C-gather stage.

---
 rtl/feed_a.sv | 135 +++++++++++++
 tb/tb_feed_a.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/feed_a.sv
// feed_a: reads A row segments from BRAM and feeds them diagonally skewed into the systolic array
//   in : clk, rst, start_cal, block_ack, bram_rddata_a
//   out: feed_busy, block_done, feed_done, bram_clk_a, bram_en_a, bram_addr_a,
//        a_ins (lane i = [i*W +: W]), a_valid, debug_state, debug_row_cnt, debug_blk_cnt
module feed_a #(
    parameter int W             = 8,
    parameter int N             = 16,
    parameter int BRAM_W        = 256,
    parameter int BRAM_AW       = 10,
    parameter int DATA_A_SIZE_X = 64,
    parameter int DATA_A_SIZE_Y = 64,
    localparam int NBLK = DATA_A_SIZE_X / N,
    localparam int SEG  = BRAM_W / (N * W),
    localparam int WPR  = DATA_A_SIZE_X * W / BRAM_W,
    localparam int RW   = DATA_A_SIZE_Y > 1 ? $clog2(DATA_A_SIZE_Y) : 1,
    localparam int BW   = NBLK > 1 ? $clog2(NBLK) : 1,
    localparam int SW   = SEG > 1 ? $clog2(SEG) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_cal,
    input  logic                block_ack,
    output logic                feed_busy,
    output logic                block_done,
    output logic                feed_done,
    output logic                bram_clk_a,
    output logic                bram_en_a,
    output logic [BRAM_AW-1:0]  bram_addr_a,
    input  logic [BRAM_W-1:0]   bram_rddata_a,
    output logic [N*W-1:0]      a_ins,
    output logic [N-1:0]        a_valid,
    output logic [2:0]          debug_state,
    output logic [RW-1:0]       debug_row_cnt,
    output logic [BW-1:0]       debug_blk_cnt
);
    typedef enum logic [2:0] {IDLE = 3'd0, READ = 3'd1, DRAIN = 3'd2, WAIT_ACK = 3'd3} state_t;

    state_t state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [BW-1:0] blk_q, blk_d;
    logic en_d1;
    logic [SW-1:0] seg_d1;
    logic [SEG-1:0][N*W-1:0] words;
    logic [N*W-1:0] seg_word;
    logic empty;

    assign bram_clk_a    = clk;
    assign feed_busy     = state_q != IDLE;
    assign debug_state   = state_q;
    assign debug_row_cnt = row_q;
    assign debug_blk_cnt = blk_q;
    assign words         = bram_rddata_a;
    assign seg_word      = words[seg_d1];
    // block is finished once nothing is left in flight, i.e. the cycle after the last lane's last valid
    assign empty         = !en_d1 && !(|a_valid);
    assign bram_addr_a   = bram_en_a ? BRAM_AW'(int'(row_q) * WPR + int'(blk_q) / SEG) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        blk_d      = blk_q;
        bram_en_a  = 1'b0;
        block_done = 1'b0;
        feed_done  = 1'b0;
        case (state_q)
            IDLE: if (start_cal) begin
                state_d = READ;
                row_d   = '0;
                blk_d   = '0;
            end
            READ: begin
                bram_en_a = 1'b1;
                if (row_q == RW'(DATA_A_SIZE_Y - 1)) state_d = DRAIN;
                else row_d = row_q + 1'b1;
            end
            DRAIN: if (empty) begin
                block_done = 1'b1;
                feed_done  = blk_q == BW'(NBLK - 1);
                state_d    = feed_done ? IDLE : WAIT_ACK;
            end
            WAIT_ACK: if (block_ack) begin
                state_d = READ;
                row_d   = '0;
                blk_d   = blk_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // segment select rides along with the read request through the BRAM latency
    always_ff @(posedge clk) begin
        if (rst) begin
            en_d1  <= 1'b0;
            seg_d1 <= '0;
        end else begin
            en_d1  <= bram_en_a;
            seg_d1 <= SW'(int'(blk_q) % SEG);
        end
    end

    // lane i: one capture stage plus i delay stages; data is zeroed whenever the lane is idle
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] d [0:i];
        logic         v [0:i];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= i; k++) begin
                    d[k] <= '0;
                    v[k] <= 1'b0;
                end
            end else begin
                d[0] <= en_d1 ? seg_word[i*W +: W] : '0;
                v[0] <= en_d1;
                for (int k = 1; k <= i; k++) begin
                    d[k] <= d[k-1];
                    v[k] <= v[k-1];
                end
            end
        end
        assign a_valid[i]        = v[i];
        assign a_ins[i*W +: W]   = v[i] ? d[i] : '0;
    end
endmodule

// File: tb/tb_feed_a.sv
// tb_feed_a: directed self-checking bench for feed_a with a behavioural BRAM holding A[r][c] = (r*64+c) mod 256
module tb_feed_a;
    logic clk = 0;
    logic rst = 1;
    logic start_cal = 0;
    logic block_ack = 0;
    logic feed_busy, block_done, feed_done, bram_clk_a, bram_en_a;
    logic [9:0] bram_addr_a;
    logic [255:0] bram_rddata_a = {8{32'hA5C3_5A3C}};
    logic [127:0] a_ins;
    logic [15:0] a_valid;
    logic [2:0] debug_state;
    logic [5:0] debug_row_cnt;
    logic [1:0] debug_blk_cnt;
    int total = 0;
    int bad = 0;

    feed_a dut (
        .clk(clk), .rst(rst), .start_cal(start_cal), .block_ack(block_ack),
        .feed_busy(feed_busy), .block_done(block_done), .feed_done(feed_done),
        .bram_clk_a(bram_clk_a), .bram_en_a(bram_en_a), .bram_addr_a(bram_addr_a),
        .bram_rddata_a(bram_rddata_a), .a_ins(a_ins), .a_valid(a_valid),
        .debug_state(debug_state), .debug_row_cnt(debug_row_cnt), .debug_blk_cnt(debug_blk_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] word_of(input logic [9:0] a);
        logic [255:0] w;
        int r, s;
        r = int'(a) / 2;
        s = int'(a) % 2;
        for (int j = 0; j < 32; j++) w[j*8 +: 8] = 8'((r * 64 + s * 32 + j) % 256);
        return w;
    endfunction

    // BRAM holds its last output when not enabled, so idle-lane zeroing is really exercised
    always @(posedge clk) if (bram_en_a) bram_rddata_a <= word_of(bram_addr_a);

    task automatic check_idle_outputs(input string tag);
        total++;
        if ({feed_busy, block_done, feed_done, bram_en_a} !== 4'b0) begin
            bad++;
            $display("FAIL %s ctrl got=%b exp=0000", tag, {feed_busy, block_done, feed_done, bram_en_a});
        end
        total++;
        if (bram_addr_a !== 10'd0) begin bad++; $display("FAIL %s addr got=%0d exp=0", tag, bram_addr_a); end
        total++;
        if (a_valid !== 16'd0) begin bad++; $display("FAIL %s a_valid got=%h exp=0", tag, a_valid); end
        total++;
        if (a_ins !== 128'd0) begin bad++; $display("FAIL %s a_ins got=%h exp=0", tag, a_ins); end
        total++;
        if ({debug_state, debug_row_cnt, debug_blk_cnt} !== 11'd0) begin
            bad++;
            $display("FAIL %s debug got=%0d/%0d/%0d exp=0/0/0", tag, debug_state, debug_row_cnt, debug_blk_cnt);
        end
    endtask

    // runs one block from its first READ cycle (k=0) to one cycle after block_done (k=82)
    task automatic check_block(input int b);
        logic [15:0] ev;
        logic [127:0] ea;
        int r;
        logic [2:0] st_e;
        for (int k = 0; k <= 82; k++) begin
            @(negedge clk);
            if (k == 0) begin start_cal = 0; block_ack = 0; end
            if (k == 10) start_cal = 1;
            if (k == 11) start_cal = 0;
            if (k == 20) block_ack = 1;
            if (k == 21) block_ack = 0;
            ev = '0;
            ea = '0;
            for (int i = 0; i < 16; i++) begin
                r = k - 2 - i;
                if (r >= 0 && r < 64) begin
                    ev[i] = 1'b1;
                    ea[i*8 +: 8] = 8'((r * 64 + b * 16 + i) % 256);
                end
            end
            st_e = k < 64 ? 3'd1 : k < 82 ? 3'd2 : (b == 3 ? 3'd0 : 3'd3);
            if (k == 0) begin
                total++;
                if (debug_blk_cnt !== 2'(b) || debug_row_cnt !== 6'd0) begin
                    bad++;
                    $display("FAIL blk_start b=%0d got=%0d/%0d exp=%0d/0", b, debug_blk_cnt, debug_row_cnt, b);
                end
            end
            total++;
            if (bram_en_a !== (k < 64)) begin bad++; $display("FAIL en b=%0d k=%0d got=%b exp=%b", b, k, bram_en_a, k < 64); end
            if (k < 64) begin
                total++;
                if (bram_addr_a !== 10'(2 * k + b / 2)) begin
                    bad++;
                    $display("FAIL addr b=%0d k=%0d got=%0d exp=%0d", b, k, bram_addr_a, 2 * k + b / 2);
                end
            end
            total++;
            if (a_valid !== ev) begin bad++; $display("FAIL a_valid b=%0d k=%0d got=%h exp=%h", b, k, a_valid, ev); end
            total++;
            if (a_ins !== ea) begin bad++; $display("FAIL a_ins b=%0d k=%0d got=%h exp=%h", b, k, a_ins, ea); end
            total++;
            if (block_done !== (k == 81) || feed_done !== (k == 81 && b == 3)) begin
                bad++;
                $display("FAIL done b=%0d k=%0d got=%b%b exp=%b%b", b, k, block_done, feed_done, k == 81, k == 81 && b == 3);
            end
            total++;
            if (debug_state !== st_e || feed_busy !== (st_e != 3'd0)) begin
                bad++;
                $display("FAIL state b=%0d k=%0d got=%0d/%b exp=%0d", b, k, debug_state, feed_busy, st_e);
            end
            if (b == 3 && k == 5) begin
                total++;
                if (bram_addr_a !== 10'd11) begin bad++; $display("FAIL addr_b3r5 got=%0d exp=11", bram_addr_a); end
            end
            if (b == 3 && k == 14) begin
                total++;
                if (a_ins[63:56] !== 8'd119) begin bad++; $display("FAIL lane7_b3r5 got=%0d exp=119", a_ins[63:56]); end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 0;
        @(negedge clk);
        check_idle_outputs("idle");
    endtask

    task automatic test_basic;
        start_cal = 1;
        check_block(0);
    endtask

    task automatic test_stall;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            total++;
            if (debug_state !== 3'd3 || bram_en_a !== 1'b0 || feed_busy !== 1'b1) begin
                bad++;
                $display("FAIL stall k=%0d got=%0d/%b/%b exp=3/0/1", k, debug_state, bram_en_a, feed_busy);
            end
        end
        block_ack = 1;
    endtask

    task automatic test_blocks;
        check_block(1);
        block_ack = 1;
        check_block(2);
        block_ack = 1;
        check_block(3);
    endtask

    task automatic test_full;
        block_ack = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            if (bram_en_a !== 1'b0 || feed_busy !== 1'b0 || block_done !== 1'b0 || feed_done !== 1'b0) begin
                bad++;
                $display("FAIL after_full k=%0d got=%b%b%b%b exp=0000", k, bram_en_a, feed_busy, block_done, feed_done);
            end
        end
        block_ack = 0;
    endtask

    task automatic test_reset_mid;
        start_cal = 1;
        check_block(0);
        block_ack = 1;
        for (int k = 0; k <= 30; k++) begin
            @(negedge clk);
            if (k == 0) block_ack = 0;
        end
        total++;
        if (debug_row_cnt !== 6'd30 || debug_blk_cnt !== 2'd1) begin
            bad++;
            $display("FAIL mid_pos got=%0d/%0d exp=30/1", debug_row_cnt, debug_blk_cnt);
        end
        rst = 1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        rst = 0;
        start_cal = 1;
        check_block(0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_blocks;
        test_full;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
